instr_mem_loadable: RTL and testbench
=====================================

# instr_mem_loadable

Parametrised, loadable instruction memory for the single-cycle and pipelined MIPS cores. It replaces fixed hard-wired program words with a synchronous RAM that is cleared to NOP after reset and filled through a streaming load port, then serves fetches through a valid/ready handshake with one-cycle latency. Misaligned and out-of-range fetches are flagged as faults instead of aliasing. It sits between the PC/IF stage and the program loader (testbench or UART bootloader).

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 32, number of words; power of two, ≥ 2
- NOP_WORD, 32'h0000_0000, fill value for clear and for faulted responses (sll $0,$0,0)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- load_en  in  1  request loader mode
- load_valid  in  1  load word present
- load_data  in  DATA_W  word to write
- load_ready  out  1  loader accepts a word this cycle
- load_count  out  $clog2(DEPTH)+1  words written since entering LOAD, saturates at DEPTH
- fetch_valid  in  1  fetch request
- fetch_addr  in  32  byte address (PC)
- fetch_ready  out  1  fetch accepted when fetch_valid & fetch_ready
- instr_valid  out  1  response present
- instr  out  DATA_W  fetched word
- instr_fault  out  1  response is misaligned (addr[1:0]≠0) or out of range (addr>>2 ≥ DEPTH)
- instr_ready  in  1  consumer takes response
- busy  out  1  high in CLEAR or LOAD

## Operation
- States: CLEAR, RUN, LOAD. Reset → CLEAR, clear pointer 0.
- CLEAR: writes NOP_WORD to word[ptr] each cycle, ptr++; after word DEPTH-1 → RUN. Takes exactly DEPTH cycles.
- RUN: fetch_ready = !instr_valid | instr_ready. Accepted fetch reads word[fetch_addr>>2]; faulted fetch does not read RAM, returns instr=NOP_WORD, instr_fault=1.
- RUN → LOAD when load_en=1 and no response pending (instr_valid=0); fetch_ready=0 in that cycle. Write pointer and load_count reset to 0 on entry.
- LOAD: load_ready=1; each load_valid handshake writes load_data to word[ptr], ptr++ modulo DEPTH (wrap overwrites word 0), load_count++ saturating at DEPTH. fetch_ready=0.
- LOAD → RUN when load_en=0 (a word presented in that same cycle is not accepted; load_ready=0).
- Contents persist across RUN/LOAD; only reset clears.

## Timing
- Reset values: load_ready 0, load_count 0, fetch_ready 0, instr_valid 0, instr 0, instr_fault 0, busy 1.
- Fetch latency 1 cycle: handshake at edge N → instr_valid, instr, instr_fault valid after edge N+1.
- Back-to-back fetches with instr_ready=1: one response per cycle.
- instr_valid=1 & instr_ready=0: instr, instr_fault held stable, fetch_ready=0.
- Response consumed and new fetch accepted same cycle: instr_valid stays 1, data updates.
- Write then fetch of same word: fetch after returning to RUN sees new data (no bypass needed; LOAD exit costs ≥1 cycle).
- reset mid-LOAD or mid-response: drops response, restarts CLEAR, contents re-cleared.
- First fetch accepted at cycle DEPTH after reset deassertion.

## Structure
- Shared package mips_pkg: NOP_WORD default, state enum {CLEAR, RUN, LOAD}, opcode constants already used by test programs.
- One sub-module: sp_ram (single-port synchronous RAM, DATA_W × DEPTH, write-enable, registered read); FSM, pointer, and handshake in the top.

## Test plan
- Reset, hold fetch_valid=1 addr 0 → fetch_ready=0 for 32 cycles; first response instr=32'h0, fault=0.
- LOAD words 32'h2008_0020, 32'h2009_0027, drop load_en, fetch 0x0 and 0x4 back-to-back → responses 32'h2008_0020 then 32'h2009_0027 on consecutive cycles, load_count=2.
- Fetch 0x6 → instr=NOP, instr_fault=1; fetch 0x80 (DEPTH=32) → instr_fault=1, RAM unchanged.
- Hold instr_ready=0 3 cycles after a response → instr stable, fetch_ready=0; release → next queued fetch accepted same cycle.
- Load 33 words with value=index → word 0 = 32, load_count=32 (saturated), word 1 = 1.
- Assert reset during LOAD after 5 words → busy=1, full CLEAR; fetch 0x0 returns 32'h0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: NOP fill word, instruction-memory states
// and opcode constants used by the test programs.
package mips_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_LOAD
  } mem_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/instr_mem_loadable_sp_ram.sv
// Single-port synchronous RAM; the read register only
// updates on a read so a stalled response stays put.
module sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: clears to NOP after reset, takes a
// streamed program in LOAD, serves 1-cycle fetches in RUN.
module instr_mem_loadable
  import mips_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  output logic                       load_ready,
  output logic [$clog2(DEPTH):0]     load_count,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_addr,
  output logic                       fetch_ready,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr,
  output logic                       instr_fault,
  input  logic                       instr_ready,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mem_state_e        state;
  logic [AW-1:0]     ptr;
  logic [CW-1:0]     count;
  logic              rsp_valid;
  logic              rsp_fault;
  logic [DATA_W-1:0] rdata;

  logic              fetch_bad;
  logic              fetch_fire;
  logic              load_fire;
  logic              ram_we;
  logic              ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // Out of range means any bit above the word index is set.
  assign fetch_bad  = (|fetch_addr[1:0]) | (|fetch_addr[31:AW+2]);

  // Loader has priority: a pending load request blocks new fetches.
  assign fetch_ready = (state == ST_RUN) & ~load_en
                     & (~rsp_valid | instr_ready);
  assign fetch_fire  = fetch_valid & fetch_ready;

  assign load_ready = (state == ST_LOAD) & load_en;
  assign load_fire  = load_ready & load_valid;

  assign ram_we    = (state == ST_CLEAR) | load_fire;
  assign ram_re    = fetch_fire & ~fetch_bad;
  assign ram_addr  = ram_we ? ptr : fetch_addr[AW+1:2];
  assign ram_wdata = (state == ST_CLEAR) ? NOP_WORD : load_data;

  assign instr_valid = rsp_valid;
  assign instr_fault = rsp_fault;
  assign instr       = !rsp_valid ? '0
                     : rsp_fault  ? NOP_WORD
                     : rdata;
  assign load_count  = count;
  assign busy        = (state != ST_RUN);

  sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      ptr       <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(DEPTH - 1))
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (fetch_fire) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fetch_bad;
          end else if (instr_ready) begin
            rsp_valid <= 1'b0;
          end
          if (load_en && !rsp_valid) begin
            state <= ST_LOAD;
            ptr   <= '0;
            count <= '0;
          end
        end
        ST_LOAD: begin
          if (!load_en) begin
            state <= ST_RUN;
          end else if (load_valid) begin
            ptr <= ptr + 1'b1;
            if (count != CW'(DEPTH))
              count <= count + 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomised bench for instr_mem_loadable against an
// array-based memory model with a one-entry response slot.
module tb_instr_mem_loadable;

  localparam int DEPTH = 32;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [5:0]  load_count;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_fault;
  logic        instr_ready;
  logic        busy;

  instr_mem_loadable dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_fault (instr_fault),
    .instr_ready (instr_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_ptr;
  int          m_cnt;
  bit          m_valid;
  bit          m_fault;
  logic [31:0] m_data;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  // One cycle of fetch traffic; caller sits just after a posedge.
  task automatic fetch_cycle(input bit v, input logic [31:0] a,
                             input bit rdy, output bit fired);
    bit exp_rdy;
    bit bad;
    fetch_valid = v;
    fetch_addr  = a;
    instr_ready = rdy;
    @(negedge clk);
    exp_rdy = !m_valid || rdy;
    check("fetch_ready", {31'b0, fetch_ready}, {31'b0, exp_rdy});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check("instr", instr, m_data);
      check("instr_fault", {31'b0, instr_fault}, {31'b0, m_fault});
    end
    fired = v && exp_rdy;
    @(posedge clk); #1;
    if (fired) begin
      bad     = (a % 4 != 0) || (a / 4 >= DEPTH);
      m_valid = 1'b1;
      m_fault = bad;
      m_data  = bad ? NOP : m_mem[a / 4];
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    fetch_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    int guard = 0;
    while (m_valid && guard < 4) begin
      fetch_cycle(1'b0, 32'h0, 1'b1, f);
      guard++;
    end
  endtask

  // Reset, then hold a fetch of word 0 until the memory leaves CLEAR.
  task automatic do_reset();
    int wait_cyc = 0;
    reset       = 1'b1;
    load_en     = 1'b0;
    load_valid  = 1'b0;
    fetch_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_fready", {31'b0, fetch_ready}, 32'h0);
    check("rst_ivalid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_fault", {31'b0, instr_fault}, 32'h0);
    check("rst_lready", {31'b0, load_ready}, 32'h0);
    check("rst_lcount", {26'b0, load_count}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_valid = 1'b0;
    m_cnt   = 0;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    @(negedge clk);
    while (!fetch_ready && wait_cyc < 100) begin
      wait_cyc++;
      @(negedge clk);
    end
    check("clear_cycles", wait_cyc, DEPTH);
    @(posedge clk); #1;
    m_valid = 1'b1;
    m_fault = 1'b0;
    m_data  = m_mem[0];
    fetch_valid = 1'b0;
  endtask

  task automatic enter_load();
    drain();
    load_en    = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    check("ld_entry_frdy", {31'b0, fetch_ready}, 32'h0);
    @(posedge clk); #1;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic push_word(input logic [31:0] w, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) begin
      load_valid = 1'b0;
      @(negedge clk);
      check("ld_busy", {31'b0, busy}, 32'h1);
      @(posedge clk); #1;
    end
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    check("ld_ready", {31'b0, load_ready}, 32'h1);
    @(posedge clk); #1;
    m_mem[m_ptr] = w;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_cnt < DEPTH) m_cnt++;
    load_valid = 1'b0;
  endtask

  task automatic exit_load();
    load_en    = 1'b0;
    load_valid = 1'b1;
    load_data  = $urandom;
    @(negedge clk);
    check("ld_exit_ready", {31'b0, load_ready}, 32'h0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("ld_count", {26'b0, load_count}, m_cnt);
    check("ld_exit_busy", {31'b0, busy}, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] a;
    a = 32'($urandom_range(0, DEPTH - 1)) * 4;
    if (r == 7) a = a + 32'($urandom_range(1, 3));
    if (r == 8) a = 32'h80 + a;
    if (r == 9) a = $urandom | 32'h8000_0000;
    return a;
  endfunction

  initial begin
    bit f;
    load_data  = '0;
    fetch_addr = '0;

    do_reset();
    fetch_cycle(1'b0, 32'h0, 1'b1, f);

    enter_load();
    push_word(32'h2008_0020, 0);
    push_word(32'h2009_0027, 0);
    exit_load();
    check("lc_two", {26'b0, load_count}, 32'd2);
    fetch_cycle(1'b1, 32'h0, 1'b1, f);
    fetch_cycle(1'b1, 32'h4, 1'b1, f);
    fetch_cycle(1'b1, 32'h6, 1'b1, f);
    fetch_cycle(1'b1, 32'h80, 1'b1, f);
    fetch_cycle(1'b1, 32'h0, 1'b1, f);
    fetch_cycle(1'b0, 32'h0, 1'b1, f);

    fetch_cycle(1'b1, 32'h0, 1'b1, f);
    repeat (3) fetch_cycle(1'b1, 32'h4, 1'b0, f);
    fetch_cycle(1'b1, 32'h4, 1'b1, f);
    check("stall_release", {31'b0, f}, 32'h1);
    fetch_cycle(1'b0, 32'h0, 1'b1, f);

    enter_load();
    for (int i = 0; i <= DEPTH; i++) push_word(32'(i), 20);
    exit_load();
    check("lc_sat", {26'b0, load_count}, DEPTH);
    fetch_cycle(1'b1, 32'h0, 1'b1, f);
    fetch_cycle(1'b1, 32'h4, 1'b1, f);
    fetch_cycle(1'b0, 32'h0, 1'b1, f);

    enter_load();
    for (int i = 0; i < 5; i++) push_word($urandom | 32'h1, 0);
    do_reset();
    fetch_cycle(1'b0, 32'h0, 1'b1, f);
    fetch_cycle(1'b1, 32'h4, 1'b1, f);
    fetch_cycle(1'b0, 32'h0, 1'b1, f);

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 40);
      enter_load();
      for (int i = 0; i < n; i++) push_word($urandom, 25);
      exit_load();
      for (int i = 0; i < 40; i++)
        fetch_cycle($urandom_range(0, 3) != 0, rand_addr(),
                    $urandom_range(0, 2) != 0, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
